// File: rtl/ps2_joy.sv
// PS/2 keyboard receiver that turns scan-code set 2 make/break codes into a
// Dendy gamepad byte (1 = pressed). The bit layout and polarity match joy1.
module ps2_joy #(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] joy,
    output logic [7:0] code,
    output logic       code_stb,
    output logic       err
);

    localparam int unsigned FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    // Scan codes
    localparam logic [7:0] CodeBreak = 8'hF0;
    localparam logic [7:0] CodeExt   = 8'hE0;
    localparam logic [7:0] CodeX     = 8'h22;
    localparam logic [7:0] CodeZ     = 8'h1A;
    localparam logic [7:0] CodeTab   = 8'h0D;
    localparam logic [7:0] CodeEnter = 8'h5A;
    localparam logic [7:0] CodeUp    = 8'h75;
    localparam logic [7:0] CodeDown  = 8'h72;
    localparam logic [7:0] CodeLeft  = 8'h6B;
    localparam logic [7:0] CodeRight = 8'h74;

    logic          clk_s1_q, clk_s2_q;
    logic          dat_s1_q, dat_s2_q;
    logic          clk_f_q;
    logic [FW-1:0] filt_cnt_q;
    logic [3:0]    bit_cnt_q;
    logic [9:0]    shreg_q;
    logic [IW-1:0] idle_cnt_q;
    logic          ext_q, brk_q;

    logic          clk_flip;
    logic          fall;
    logic          frame_ok;
    logic          timeout_hit;

    // The filtered clock flips on the FILTER-th consecutive differing sample
    always_comb begin
        clk_flip    = (clk_s2_q != clk_f_q) && (filt_cnt_q == FW'(FILTER - 1));
        fall        = clk_flip && clk_f_q;
        // shreg holds start in [0], data in [8:1], parity in [9]; stop is live
        frame_ok    = !shreg_q[0] && dat_s2_q && (^shreg_q[9:1]);
        timeout_hit = !fall && (bit_cnt_q != 4'd0) && (idle_cnt_q == IW'(TIMEOUT - 1));
    end

    // Two-flop synchronisers on both raw lines
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filter: count consecutive samples that disagree with clk_f_q
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_f_q    <= 1'b1;
            filt_cnt_q <= '0;
        end else if (clk_s2_q == clk_f_q) begin
            filt_cnt_q <= '0;
        end else if (clk_flip) begin
            clk_f_q    <= clk_s2_q;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + FW'(1);
        end
    end

    // Idle counter: cleared on each bit, saturates so a timeout pulses once
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_q <= '0;
        end else if (fall) begin
            idle_cnt_q <= '0;
        end else if ((bit_cnt_q != 4'd0) && (idle_cnt_q < IW'(TIMEOUT))) begin
            idle_cnt_q <= idle_cnt_q + IW'(1);
        end
    end

    // Frame assembly and check; code_stb / err are single-cycle pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q <= 4'd0;
            shreg_q   <= '0;
            code      <= 8'h00;
            code_stb  <= 1'b0;
            err       <= 1'b0;
        end else begin
            code_stb <= 1'b0;
            err      <= 1'b0;
            if (fall) begin
                if (bit_cnt_q == 4'd10) begin
                    bit_cnt_q <= 4'd0;
                    shreg_q   <= '0;
                    if (frame_ok) begin
                        code     <= shreg_q[8:1];
                        code_stb <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end else begin
                    shreg_q   <= {dat_s2_q, shreg_q[9:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else if (timeout_hit) begin
                // Drop the partial frame; next falling edge starts a fresh one
                bit_cnt_q <= 4'd0;
                shreg_q   <= '0;
                err       <= 1'b1;
            end
        end
    end

    // Decoder: prefixes accumulate, any other byte consumes and clears them
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            joy   <= 8'h00;
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (code_stb) begin
            if (code == CodeBreak) begin
                brk_q <= 1'b1;
            end else if (code == CodeExt) begin
                ext_q <= 1'b1;
            end else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
                if (!ext_q) begin
                    case (code)
                        CodeX:     joy[0] <= !brk_q;
                        CodeZ:     joy[1] <= !brk_q;
                        CodeTab:   joy[2] <= !brk_q;
                        CodeEnter: joy[3] <= !brk_q;
                        default:   ;
                    endcase
                end else begin
                    case (code)
                        CodeUp:    joy[4] <= !brk_q;
                        CodeDown:  joy[5] <= !brk_q;
                        CodeLeft:  joy[6] <= !brk_q;
                        CodeRight: joy[7] <= !brk_q;
                        default:   ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_joy.sv
// Bench for ps2_joy: table of scan-code frames plus hand-written sequences for
// timeout, clock glitches and mid-frame reset. Bit timing and TIMEOUT are
// scaled down so the run stays short.
module tb_ps2_joy;

    localparam int unsigned FILTER  = 8;
    localparam int unsigned TIMEOUT = 400;
    localparam int          HALF    = 20;   // half bit period in system clocks

    logic       clock;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] joy;
    logic [7:0] code;
    logic       code_stb;
    logic       err;

    ps2_joy #(
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .joy      (joy),
        .code     (code),
        .code_stb (code_stb),
        .err      (err)
    );

    initial clock = 1'b0;
    always #20 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        logic [7:0] exp_joy;
        int         exp_err;
    } vec_t;

    vec_t       vecs[18];
    logic [7:0] exp_q[$];
    logic [7:0] exp_code;
    logic [7:0] obs_code[64];
    int         stb_cnt = 0;
    int         err_cnt = 0;
    int         rd_idx  = 0;
    int         checks  = 0;
    int         failures = 0;

    // Monitor: record every code_stb pulse and count err pulses
    always @(negedge clock) begin
        if (code_stb) begin
            obs_code[stb_cnt[5:0]] <= code;
            stb_cnt <= stb_cnt + 1;
        end
        if (err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drive the first nbits of a frame the way a keyboard does: data changes
    // while clock is high, host samples on the falling edge.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            wait_clk(HALF);
            ps2_clk = 1'b0;
            wait_clk(HALF);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        if (nbits == 11 && !bad_par) begin
            exp_q.push_back(d);
            exp_code = d;
        end
    endtask

    // Compare every observed code_stb against the scoreboard queue
    task automatic drain(input string name);
        wait_clk(10);
        while (rd_idx < stb_cnt) begin
            if (exp_q.size() == 0) begin
                check({name, "_unexpected_stb"}, int'(obs_code[rd_idx[5:0]]), -1);
            end else begin
                check({name, "_stb_code"}, int'(obs_code[rd_idx[5:0]]), int'(exp_q.pop_front()));
            end
            rd_idx++;
        end
        check({name, "_pending_exp"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input bit bad_par,
                             input logic [7:0] exp_joy, input int exp_err);
        int stb0, err0;
        stb0 = stb_cnt;
        err0 = err_cnt;
        send_frame(d, bad_par, 11);
        drain(name);
        check({name, "_stb_pulses"}, stb_cnt - stb0, bad_par ? 0 : 1);
        check({name, "_err_pulses"}, err_cnt - err0, exp_err);
        check({name, "_joy"}, int'(joy), int'(exp_joy));
        check({name, "_code"}, int'(code), int'(exp_code));
    endtask

    initial begin
        int stb0, err0;

        vecs[0]  = '{8'h22, 1'b0, 8'h01, 0};  // X make -> A
        vecs[1]  = '{8'hF0, 1'b0, 8'h01, 0};
        vecs[2]  = '{8'h22, 1'b0, 8'h00, 0};  // X break
        vecs[3]  = '{8'hE0, 1'b0, 8'h00, 0};
        vecs[4]  = '{8'h75, 1'b0, 8'h10, 0};  // Up
        vecs[5]  = '{8'hE0, 1'b0, 8'h10, 0};
        vecs[6]  = '{8'h6B, 1'b0, 8'h50, 0};  // Left
        vecs[7]  = '{8'hE0, 1'b0, 8'h50, 0};
        vecs[8]  = '{8'hF0, 1'b0, 8'h50, 0};
        vecs[9]  = '{8'h75, 1'b0, 8'h40, 0};  // Up break
        vecs[10] = '{8'h75, 1'b0, 8'h40, 0};  // keypad 8: prefixes were cleared
        vecs[11] = '{8'h5A, 1'b1, 8'h40, 1};  // parity error
        vecs[12] = '{8'h5A, 1'b0, 8'h48, 0};  // Start
        vecs[13] = '{8'h5A, 1'b0, 8'h48, 0};  // typematic repeat
        vecs[14] = '{8'hF0, 1'b0, 8'h48, 0};
        vecs[15] = '{8'hAA, 1'b0, 8'h48, 0};  // unmapped, consumes brk
        vecs[16] = '{8'h5A, 1'b0, 8'h48, 0};  // brk gone, still pressed
        vecs[17] = '{8'h72, 1'b0, 8'h48, 0};  // Down without E0: keypad 2

        exp_code = 8'h00;
        ps2_clk  = 1'b1;
        ps2_dat  = 1'b1;
        reset_n  = 1'b0;
        wait_clk(5);
        check("reset_joy", int'(joy), 0);
        check("reset_code", int'(code), 0);
        check("reset_code_stb", int'(code_stb), 0);
        check("reset_err", int'(err), 0);
        reset_n = 1'b1;
        wait_clk(5);

        for (int i = 0; i < 18; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].bad_par,
                      vecs[i].exp_joy, vecs[i].exp_err);
        end

        // Partial frame then idle past TIMEOUT: exactly one err pulse
        stb0 = stb_cnt;
        err0 = err_cnt;
        send_frame(8'h1A, 1'b0, 5);
        wait_clk(2 * TIMEOUT);
        check("timeout_err", err_cnt - err0, 1);
        check("timeout_stb", stb_cnt - stb0, 0);
        run_frame("after_timeout", 8'h1A, 1'b0, 8'h4A, 0);

        // Short glitches on ps2_clk must not count as bits
        stb0 = stb_cnt;
        err0 = err_cnt;
        for (int g = 0; g < 3; g++) begin
            ps2_clk = 1'b0;
            wait_clk(FILTER / 2);
            ps2_clk = 1'b1;
            wait_clk(HALF);
        end
        wait_clk(TIMEOUT + 100);
        check("glitch_err", err_cnt - err0, 0);
        check("glitch_stb", stb_cnt - stb0, 0);
        run_frame("after_glitch", 8'h22, 1'b0, 8'h4B, 0);

        // Reset in the middle of a frame clears everything asynchronously
        run_frame("hold_z", 8'h1A, 1'b0, 8'h4B, 0);
        send_frame(8'h22, 1'b0, 4);
        reset_n = 1'b0;
        #1;
        check("midreset_joy", int'(joy), 0);
        check("midreset_code", int'(code), 0);
        check("midreset_code_stb", int'(code_stb), 0);
        exp_code = 8'h00;
        wait_clk(5);
        reset_n = 1'b1;
        wait_clk(10);
        drain("midreset");
        run_frame("after_reset", 8'h0D, 1'b0, 8'h04, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
